// File: rtl/roulette_pkg.sv
// Shared types and constants for the roulette wheel spinner and the games that
// reuse its LFSR.
`default_nettype none

package roulette_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SPIN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Feedback taps 16,14,13,11 expressed as a mask over q[15:0].
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam int unsigned MIN_STEPS    = 32;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

`default_nettype wire

// File: rtl/roulette_wheel_spinner_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; a zero seed would lock it up, so seed
// must be nonzero.
`default_nettype none

module lfsr16
    import roulette_pkg::*;
(
    input  logic        Clock,
    input  logic        reset_n,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= seed;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

`default_nettype wire

// File: rtl/roulette_wheel_spinner.sv
// Decelerating roulette wheel: a synced press on spin_n starts a spin of
// 32..63 steps whose per-step interval grows by STEP_INC each step.
`default_nettype none

module roulette_wheel_spinner
    import roulette_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 32,
    parameter int unsigned BASE_DIV  = 2_500_000,
    parameter int unsigned STEP_INC  = 250_000,
    parameter logic [15:0] SEED      = DEFAULT_SEED
) (
    input  logic       Clock,
    input  logic       reset_n,
    input  logic       spin_n,
    output logic [4:0] randnum,
    output logic       busy,
    output logic       result_valid
);

    localparam logic [31:0] BASE_W   = 32'(BASE_DIV);
    localparam logic [31:0] STEP_W   = 32'(STEP_INC);
    localparam logic [4:0]  LAST_POS = 5'(NUM_SLOTS - 1);
    localparam logic [5:0]  MIN_W    = 6'(MIN_STEPS);

    logic [15:0] lfsr_q;
    logic        lfsr_unused;

    logic        sync_meta;
    logic        sync_key;
    logic        key_prev;
    logic        spin_req;

    state_t      state_q, state_d;
    logic [5:0]  steps_q, steps_d;
    logic [31:0] interval_q, interval_d;
    logic [31:0] div_q, div_d;
    logic [4:0]  pos_q, pos_d;
    logic [31:0] next_interval;
    logic        busy_q;
    logic        valid_q;

    lfsr16 u_lfsr (
        .Clock   (Clock),
        .reset_n (reset_n),
        .seed    (SEED),
        .q       (lfsr_q)
    );

    assign lfsr_unused = ^lfsr_q[15:5];

    // Flops reset high so that a key already released at reset sees no edge.
    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b1;
            sync_key  <= 1'b1;
            key_prev  <= 1'b1;
        end else begin
            sync_meta <= spin_n;
            sync_key  <= sync_meta;
            key_prev  <= sync_key;
        end
    end

    assign spin_req      = key_prev & ~sync_key;
    assign next_interval = interval_q + STEP_W;

    always_comb begin
        state_d    = state_q;
        steps_d    = steps_q;
        interval_d = interval_q;
        div_d      = div_q;
        pos_d      = pos_q;
        unique case (state_q)
            IDLE: begin
                if (spin_req) begin
                    steps_d    = MIN_W + {1'b0, lfsr_q[4:0]};
                    interval_d = BASE_W;
                    div_d      = BASE_W;
                    state_d    = SPIN;
                end
            end
            SPIN: begin
                if (div_q == 32'd1) begin
                    pos_d   = (pos_q == LAST_POS) ? 5'd0 : pos_q + 5'd1;
                    steps_d = steps_q - 6'd1;
                    if (steps_q == 6'd1) begin
                        state_d = DONE;
                    end else begin
                        interval_d = next_interval;
                        div_d      = next_interval;
                    end
                end else begin
                    div_d = div_q - 32'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // busy/result_valid are registered from the next state so they line up
    // with the state register rather than decoding it combinationally.
    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            steps_q    <= 6'd0;
            interval_q <= 32'd0;
            div_q      <= 32'd0;
            pos_q      <= 5'd0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            steps_q    <= steps_d;
            interval_q <= interval_d;
            div_q      <= div_d;
            pos_q      <= pos_d;
            busy_q     <= (state_d == SPIN);
            valid_q    <= (state_d == DONE);
        end
    end

    assign randnum      = pos_q;
    assign busy         = busy_q;
    assign result_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_roulette_wheel_spinner.sv
// Scoreboard bench: two spinners (32 and 10 slots) with a small clock divider,
// expectations derived from the LFSR sequence and the step/interval arithmetic.
`default_nettype none

module tb_roulette_wheel_spinner;

    localparam int unsigned BASE   = 2;
    localparam int unsigned INC    = 1;
    localparam logic [15:0] SEED_V = 16'hACE1;

    typedef struct {
        int unsigned steps;
        int unsigned result;
        longint      rise_cyc;
        longint      done_cyc;
    } exp_t;

    logic       Clock = 1'b0;
    logic       reset_n;
    logic       spin0, spin1;
    logic [4:0] rn0, rn1;
    logic       bsy0, bsy1, vld0, vld1;

    longint      cyc = 0;
    logic [15:0] lfsr_model;
    exp_t        sb0[$];
    exp_t        sb1[$];
    int unsigned pos_model[2];
    int          checks = 0;
    int          passes = 0;
    logic        busy_prev[2];
    logic [4:0]  rn_prev[2];
    int          changes[2];
    int          max_rn[2];
    logic        zero_seen = 1'b0;

    always #5 Clock = ~Clock;

    roulette_wheel_spinner #(
        .NUM_SLOTS (32), .BASE_DIV (BASE), .STEP_INC (INC), .SEED (SEED_V)
    ) dut32 (
        .Clock (Clock), .reset_n (reset_n), .spin_n (spin0),
        .randnum (rn0), .busy (bsy0), .result_valid (vld0)
    );

    roulette_wheel_spinner #(
        .NUM_SLOTS (10), .BASE_DIV (BASE), .STEP_INC (INC), .SEED (SEED_V)
    ) dut10 (
        .Clock (Clock), .reset_n (reset_n), .spin_n (spin1),
        .randnum (rn1), .busy (bsy1), .result_valid (vld1)
    );

    // Polynomial x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    function automatic int unsigned slots(input int i);
        return (i == 0) ? 32 : 10;
    endfunction

    always @(posedge Clock) cyc <= cyc + 1;

    always @(posedge Clock or negedge reset_n) begin
        if (!reset_n) lfsr_model <= SEED_V;
        else          lfsr_model <= lfsr_step(lfsr_model);
    end

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: actual %0d required %0d", name, act, req);
    endtask

    task automatic fail_line(input string name);
        checks++;
        $display("FAIL %s: actual event occurred, required none", name);
    endtask

    task automatic mon(input int i, input logic [4:0] rn, input logic b, input logic v);
        exp_t e;
        int   qsz;
        qsz = (i == 0) ? sb0.size() : sb1.size();
        if (!b && !v && rn != rn_prev[i])
            fail_line($sformatf("idle_randnum_change%0d", i));
        if (b && !busy_prev[i]) begin
            changes[i] = 0;
            max_rn[i]  = int'(rn_prev[i]);
            if (qsz == 0) begin
                fail_line($sformatf("unexpected_spin%0d", i));
            end else begin
                e = (i == 0) ? sb0[0] : sb1[0];
                check($sformatf("busy_rise_cycle%0d", i), cyc, e.rise_cyc);
            end
        end
        if (rn != rn_prev[i]) changes[i]++;
        if (int'(rn) > max_rn[i]) max_rn[i] = int'(rn);
        if (v) begin
            if (qsz == 0) begin
                fail_line($sformatf("unexpected_result_valid%0d", i));
            end else begin
                if (i == 0) e = sb0.pop_front();
                else        e = sb1.pop_front();
                check($sformatf("result%0d", i), longint'(rn), longint'(e.result));
                check($sformatf("done_cycle%0d", i), cyc, e.done_cyc);
                check($sformatf("busy_low_at_valid%0d", i), longint'(b), 0);
                check($sformatf("step_count%0d", i), changes[i], longint'(e.steps));
                check($sformatf("pos_in_range%0d", i),
                      longint'(max_rn[i] <= int'(slots(i)) - 1), 1);
            end
        end
        busy_prev[i] = b;
        rn_prev[i]   = rn;
    endtask

    always @(negedge Clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                busy_prev[i] = 1'b0;
                rn_prev[i]   = 5'd0;
                changes[i]   = 0;
                max_rn[i]    = 0;
            end
        end else begin
            mon(0, rn0, bsy0, vld0);
            mon(1, rn1, bsy1, vld1);
            if (dut32.u_lfsr.q == 16'h0000) zero_seen = 1'b1;
        end
    end

    // Key drops 1 unit after an edge: synchronizer sees it 2 edges later, the
    // request cycle uses the LFSR value after those 2 edges, busy rises at the 3rd.
    task automatic press(input int i);
        exp_t        e;
        logic [15:0] l;
        int unsigned n, total;
        @(posedge Clock);
        #1;
        l     = lfsr_step(lfsr_step(lfsr_model));
        n     = 32 + int'(l[4:0]);
        total = 0;
        for (int k = 0; k < int'(n); k++) total += BASE + k * INC;
        e.steps    = n;
        e.result   = (pos_model[i] + n) % slots(i);
        e.rise_cyc = cyc + 3;
        e.done_cyc = cyc + 3 + total;
        pos_model[i] = e.result;
        if (i == 0) begin sb0.push_back(e); spin0 = 1'b0; end
        else        begin sb1.push_back(e); spin1 = 1'b0; end
    endtask

    task automatic wait_done(input int i);
        int n;
        n = 0;
        while (((i == 0) ? sb0.size() : sb1.size()) != 0 && n < 6000) begin
            @(negedge Clock);
            n++;
        end
        if (n >= 6000) fail_line($sformatf("spin_timeout%0d", i));
        @(negedge Clock);
    endtask

    task automatic reset_pulse();
        @(negedge Clock);
        #1;
        reset_n = 1'b0;
        sb0.delete();
        sb1.delete();
        pos_model[0] = 0;
        pos_model[1] = 0;
        #1;
    endtask

    initial begin
        reset_n      = 1'b0;
        spin0        = 1'b1;
        spin1        = 1'b1;
        pos_model[0] = 0;
        pos_model[1] = 0;
        repeat (3) @(negedge Clock);
        check("reset_randnum32", rn0, 0);
        check("reset_busy32", bsy0, 0);
        check("reset_valid32", vld0, 0);
        check("reset_randnum10", rn1, 0);
        check("reset_busy10", bsy1, 0);
        check("reset_valid10", vld1, 0);
        #1;
        reset_n = 1'b1;
        #1;
        check("lfsr_after_reset32", dut32.u_lfsr.q, SEED_V);
        check("lfsr_after_reset10", dut10.u_lfsr.q, SEED_V);

        // Single spin with the key held low well past completion.
        press(0);
        wait_done(0);
        repeat (30) @(negedge Clock);
        check("held_key_no_respin", bsy0, 0);
        spin0 = 1'b1;

        // Repeated spins on the 10-slot wheel.
        for (int s = 0; s < 4; s++) begin
            repeat ($urandom_range(1, 20)) @(posedge Clock);
            press(1);
            repeat ($urandom_range(3, 40)) @(posedge Clock);
            spin1 = 1'b1;
            wait_done(1);
        end

        // Second press mid-spin must be ignored.
        repeat ($urandom_range(1, 20)) @(posedge Clock);
        press(0);
        repeat ($urandom_range(10, 100)) @(posedge Clock);
        spin0 = 1'b1;
        repeat (5) @(posedge Clock);
        check("busy_during_second_press", bsy0, 1);
        spin0 = 1'b0;
        repeat (10) @(posedge Clock);
        spin0 = 1'b1;
        wait_done(0);

        // Reset in the middle of a spin, then a fresh spin from position 0.
        repeat ($urandom_range(1, 20)) @(posedge Clock);
        press(0);
        repeat (100) @(posedge Clock);
        spin0 = 1'b1;
        #1;
        check("busy_before_reset", bsy0, 1);
        reset_pulse();
        check("midspin_reset_busy", bsy0, 0);
        check("midspin_reset_randnum", rn0, 0);
        check("midspin_reset_valid", vld0, 0);
        @(negedge Clock);
        #1;
        reset_n = 1'b1;
        repeat ($urandom_range(1, 20)) @(posedge Clock);
        press(0);
        repeat (4) @(posedge Clock);
        spin0 = 1'b1;
        wait_done(0);

        // LFSR period from reset.
        reset_pulse();
        @(negedge Clock);
        #1;
        reset_n   = 1'b1;
        zero_seen = 1'b0;
        #1;
        check("lfsr_start", dut32.u_lfsr.q, SEED_V);
        repeat (65534) @(posedge Clock);
        #1;
        check("lfsr_not_early", longint'(dut32.u_lfsr.q != SEED_V), 1);
        @(posedge Clock);
        #1;
        check("lfsr_period", dut32.u_lfsr.q, SEED_V);
        check("lfsr_never_zero", zero_seen, 0);

        check("scoreboard_empty", sb0.size() + sb1.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/roulette_wheel_spinner.md
# roulette_wheel_spinner

Generates the 5-bit roulette result consumed by the even/odd and number-guess game FSMs on `randnum`. A player press on `spin_n` starts a decelerating wheel spin. A free-running 16-bit LFSR picks the number of steps, and the position advances with a growing interval so the hex display animates. When the wheel settles, the block holds the final position and pulses `result_valid` before the downstream game samples it.

## Interface
- `NUM_SLOTS`, default 32: wheel slots; legal range 2..32; position wraps to 0 after `NUM_SLOTS-1`.
- `BASE_DIV`, default 2_500_000: clock cycles per step for the first step; must be ≥1.
- `STEP_INC`, default 250_000: cycles added to the interval after each step.
- `SEED`, default 16'hACE1: LFSR reset value; must be nonzero.
- `Clock` in 1: single system clock; all logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `spin_n` in 1: active-low spin key; asynchronous to `Clock`.
- `randnum` out 5: current wheel position; animates while busy and is stable otherwise.
- `busy` out 1: high while spinning.
- `result_valid` out 1: one-cycle pulse when the wheel settles.

## Operation
- **LFSR**
  - 16-bit Fibonacci LFSR, taps 16,14,13,11; shifts every cycle unconditionally.
  - Reset value is `SEED`. Period is 65535 and it never reaches 0.
- **Spin key**
  - `spin_n` passes through a 2-flop synchronizer.
  - A spin request is a synced 1→0 transition.
- **FSM states**: IDLE, SPIN, DONE.
- **IDLE**
  - `busy`=0 and `randnum` holds its value.
  - On a spin request: `steps_left`←32+`lfsr[4:0]` (range 32..63), `interval`←`BASE_DIV`, `div_cnt`←`BASE_DIV`, go to SPIN.
- **SPIN**
  - `busy`=1 and `div_cnt` decrements each cycle.
  - When `div_cnt`==1:
    - `pos`←(`pos`+1) mod `NUM_SLOTS`
    - `interval`←`interval`+`STEP_INC`
    - `div_cnt`←new `interval`
    - `steps_left`←`steps_left`−1
  - If `steps_left` was 1 at that step, go to DONE instead of reloading.
- **DONE**: lasts one cycle; `result_valid`=1 and `busy`=0; then go to IDLE.
- **Result**: final `randnum` = (start `pos` + steps) mod `NUM_SLOTS`.
- **Widths**
  - `interval` and `div_cnt` are 32 bits wide.
  - The max interval, `BASE_DIV`+62·`STEP_INC`, must fit in 32 bits; this is a parameter constraint, with no saturation logic.
- **Boundary conditions**
  - A spin request while in SPIN or DONE is ignored and not queued.
  - A key held low produces exactly one request.
  - Wrap: with `NUM_SLOTS`=10, `pos` 9 → 0.
- **Reset, at any time including mid-spin**
  - `randnum`=0, `busy`=0, `result_valid`=0, state IDLE, LFSR=`SEED`.
  - Synchronizer flops reset to 1 so no spurious edge occurs.

## Timing
- Let the synced falling edge be visible at the edge-detector in cycle E.
- Cycle E+1: state=SPIN and `busy`=1.
- First `randnum` change occurs `BASE_DIV` cycles after SPIN entry.
- Step k (k=0..N−1) lasts `BASE_DIV`+k·`STEP_INC` cycles.
- `result_valid` is high in the cycle after the last `pos` update; `randnum` is already final in that cycle.
- All outputs are registered, with no combinational paths from input to output.

## Structure
- **Shared package `roulette_pkg`**
  - state enum {IDLE, SPIN, DONE}
  - `LFSR_TAPS` constant
  - `DEFAULT_SEED`
  - `MIN_STEPS`=32
- **Sub-module `lfsr16`**
  - Ports: `Clock`, `reset_n`, `seed`, `q[15:0]`.
  - Free-running and reused by later games.
- **Top**: synchronizer, edge detect, FSM, counters, position register.

## Test plan
- **Reset values**: assert `reset_n`=0 → `randnum`=0, `busy`=0, `result_valid`=0; after release, LFSR `q`=16'hACE1.
- **Single spin** (`BASE_DIV`=2, `STEP_INC`=1, `NUM_SLOTS`=32)
  - Stimulus: drop `spin_n` and hold.
  - `busy` rises 1 cycle after the synced edge.
  - Step count = 32+`lfsr[4:0]` from the scoreboard model.
  - Total cycles = Σ(2+k).
  - One `result_valid` pulse; final `randnum`=(0+N) mod 32.
- **Wrap**: `NUM_SLOTS`=10, sequence of spins → `randnum` never exceeds 9 and every result equals the model's mod-10 value.
- **Press while busy**: second falling edge mid-SPIN → step count and result unchanged; exactly one `result_valid`.
- **Reset mid-spin**: `reset_n` low for 1 cycle during SPIN → immediately `busy`=0 and `randnum`=0; the next press starts a fresh spin from `pos` 0.
- **LFSR period**: run 65535 cycles from reset → `q` returns to `SEED`, never 0.
